// File: rtl/sram_arbiter.sv
// Four-port SRAM arbiter: port 0 (display) has strict priority, ports 1..3 are
// served round-robin; one access in flight, acks are level-held until req drops.
module sram_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    output logic              ready0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic              ready1,
    input  logic              req2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    output logic [DATA_W-1:0] rdata2,
    output logic              ack2,
    output logic              ready2,
    input  logic              req3,
    input  logic              we3,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] wdata3,
    output logic [DATA_W-1:0] rdata3,
    output logic              ack3,
    output logic              ready3,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        grant_id,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_ISSUE} state_e;
    typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_DONE} status_e;

    logic [3:0]        req_v;
    logic [3:0]        we_v;
    logic [ADDR_W-1:0] addr_v [4];
    logic [DATA_W-1:0] wdata_v [4];

    assign req_v      = {req3, req2, req1, req0};
    assign we_v       = {we3, we2, we1, we0};
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign addr_v[2]  = addr2;
    assign addr_v[3]  = addr3;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;
    assign wdata_v[2] = wdata2;
    assign wdata_v[3] = wdata3;

    state_e            state_q, state_d;
    status_e           status_q [4];
    status_e           status_d [4];
    logic [DATA_W-1:0] rdata_q [4];
    logic [DATA_W-1:0] rdata_d [4];
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        rr_last_q, rr_last_d;

    logic [3:0] cand;
    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        cand        = '0;
        found       = 1'b0;
        winner      = '0;
        idx         = rr_last_q;

        for (int unsigned p = 0; p < 4; p++) begin
            if (status_q[p] == ST_DONE && !req_v[p]) status_d[p] = ST_FREE;
            cand[p] = req_v[p] && (status_q[p] == ST_FREE);
        end

        case (state_q)
            S_IDLE: begin
                if (cand[0]) begin
                    found  = 1'b1;
                    winner = 2'd0;
                end else begin
                    // Circular search over 1..3 starting just after the last winner.
                    for (int unsigned i = 0; i < 3; i++) begin
                        idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
                        if (!found && cand[idx]) begin
                            found  = 1'b1;
                            winner = idx;
                        end
                    end
                end
                if (found) begin
                    mem_req_d        = 1'b1;
                    mem_we_d         = we_v[winner];
                    mem_addr_d       = addr_v[winner];
                    mem_wdata_d      = wdata_v[winner];
                    grant_d          = winner;
                    status_d[winner] = ST_PEND;
                    if (winner != 2'd0) rr_last_d = winner;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d         = 1'b0;
                    if (!mem_we_q) rdata_d[grant_q] = mem_rdata;
                    status_d[grant_q] = ST_DONE;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= '0;
            rr_last_q   <= 2'd3;
            for (int unsigned p = 0; p < 4; p++) begin
                status_q[p] <= ST_FREE;
                rdata_q[p]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign ack0      = (status_q[0] == ST_DONE);
    assign ack1      = (status_q[1] == ST_DONE);
    assign ack2      = (status_q[2] == ST_DONE);
    assign ack3      = (status_q[3] == ST_DONE);
    assign ready0    = (status_q[0] == ST_FREE);
    assign ready1    = (status_q[1] == ST_FREE);
    assign ready2    = (status_q[2] == ST_FREE);
    assign ready3    = (status_q[3] == ST_FREE);
    assign rdata0    = rdata_q[0];
    assign rdata1    = rdata_q[1];
    assign rdata2    = rdata_q[2];
    assign rdata3    = rdata_q[3];
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == S_ISSUE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: expected grants are queued as stimulus is
// driven and checked by a small SRAM controller model when mem_req appears.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, we, ack, ready;
    logic [23:0] addr [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic        mem_req, mem_we, mem_ack;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  grant_id;
    logic        busy;

    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q [$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic ctl_hold   = 1'b0;
    logic inject_ack = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(24), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .rdata0(rdata[0]), .ack0(ack[0]), .ready0(ready[0]),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .rdata1(rdata[1]), .ack1(ack[1]), .ready1(ready[1]),
        .req2(req[2]), .we2(we[2]), .addr2(addr[2]), .wdata2(wdata[2]),
        .rdata2(rdata[2]), .ack2(ack[2]), .ready2(ready[2]),
        .req3(req[3]), .we3(we[3]), .addr3(addr[3]), .wdata3(wdata[3]),
        .rdata3(rdata[3]), .ack3(ack[3]), .ready3(ready[3]),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] addr_of(input int unsigned p, input int unsigned k);
        return 24'(32'hA00000 + p * 32'h1000 + k);
    endfunction

    function automatic logic [31:0] rd_of(input logic [23:0] a);
        return {8'h5A, a};
    endfunction

    task automatic push(input int unsigned p, input logic w, input logic [23:0] a,
                        input logic [31:0] wd, input logic [31:0] rd);
        txn_t t;
        t.port = 2'(p); t.we = w; t.addr = a; t.wdata = wd; t.rdata = rd;
        exp_q.push_back(t);
    endtask

    task automatic wait_ack(input int unsigned p, input int unsigned budget);
        for (int unsigned c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (ack[p]) break;
        end
        check($sformatf("ack%0d_seen", p), 64'(ack[p]), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // SRAM controller model: acks two cycles into each access.
    initial begin
        txn_t cur;
        int unsigned cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        cur = '{port: 2'd0, we: 1'b0, addr: '0, wdata: '0, rdata: '0};
        forever begin
            @(posedge clk); #2;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (inject_ack) begin
                mem_rdata = 32'hDEAD_DEAD;
                mem_ack = 1'b1;
            end else if (mem_req) begin
                if (cnt == 0) begin
                    check("grant_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check("grant_id", 64'(grant_id), 64'(cur.port));
                        check("mem_we", 64'(mem_we), 64'(cur.we));
                        check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                        if (cur.we) check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    end
                end
                cnt++;
                if (cnt == 2 && !ctl_hold) begin
                    check("mem_addr_hold", 64'(mem_addr), 64'(cur.addr));
                    mem_rdata = cur.rdata;
                    mem_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Each port drops req on ack and re-requests two cycles later.
    task automatic run_traffic(input int unsigned n0, input int unsigned n1,
                               input int unsigned n2, input int unsigned n3,
                               input logic wr, input int unsigned budget);
        int unsigned n [4];
        int unsigned rem [4];
        int unsigned done_c [4];
        int unsigned wt [4];
        n = '{n0, n1, n2, n3};
        for (int unsigned p = 0; p < 4; p++) begin
            rem[p] = n[p]; done_c[p] = 0; wt[p] = 0;
            if (rem[p] > 0) begin
                addr[p] = addr_of(p, 0); we[p] = wr; wdata[p] = {8'hC3, addr[p]}; req[p] = 1'b1;
            end
        end
        for (int unsigned c = 0; c < budget && (rem[0] + rem[1] + rem[2] + rem[3]) != 0; c++) begin
            @(posedge clk); #1;
            for (int unsigned p = 0; p < 4; p++) begin
                if (req[p] && ack[p]) begin
                    check($sformatf("rdata%0d", p), 64'(rdata[p]),
                          64'(wr ? 32'h0 : rd_of(addr[p])));
                    req[p] = 1'b0;
                    done_c[p]++;
                    rem[p]--;
                    wt[p] = 2;
                end else if (!req[p] && rem[p] > 0) begin
                    if (wt[p] > 1) wt[p]--;
                    else begin
                        wt[p] = 0;
                        addr[p] = addr_of(p, done_c[p]); we[p] = wr;
                        wdata[p] = {8'hC3, addr[p]}; req[p] = 1'b1;
                    end
                end
            end
        end
        for (int unsigned p = 0; p < 4; p++)
            check($sformatf("done%0d", p), 64'(done_c[p]), 64'(n[p]));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; we = '0;
        for (int unsigned p = 0; p < 4; p++) begin addr[p] = '0; wdata[p] = '0; end
        do_reset();

        // Reset state
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_ready", 64'(ready), 64'hF);
        check("rst_rdata", 64'(rdata[0] | rdata[1] | rdata[2] | rdata[3]), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Single read on port 2
        push(2, 1'b0, 24'h000123, 32'h0, 32'h0000BEEF);
        we[2] = 1'b0; addr[2] = 24'h000123; req[2] = 1'b1;
        @(posedge clk); #1;
        check("read_mem_req", 64'(mem_req), 64'd1);
        check("read_busy", 64'(busy), 64'd1);
        check("read_ready2", 64'(ready[2]), 64'd0);
        wait_ack(2, 10);
        check("read_rdata2", 64'(rdata[2]), 64'h0000BEEF);
        check("read_mem_req_low", 64'(mem_req), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("read_ack2_hold", 64'(ack[2]), 64'd1);
            check("read_no_regrant", 64'(mem_req), 64'd0);
        end
        req[2] = 1'b0;
        check("read_ack2_before_clear", 64'(ack[2]), 64'd1);
        @(posedge clk); #1;
        check("read_ack2_fall", 64'(ack[2]), 64'd0);
        check("read_ready2_back", 64'(ready[2]), 64'd1);

        // Dual-ack hold: port 1 then port 2, both writes
        push(1, 1'b1, 24'h00A1A1, 32'h1111_A1A1, 32'hFFFF_FFFF);
        push(2, 1'b1, 24'h00B2B2, 32'h2222_B2B2, 32'hFFFF_FFFF);
        we[1] = 1'b1; addr[1] = 24'h00A1A1; wdata[1] = 32'h1111_A1A1;
        we[2] = 1'b1; addr[2] = 24'h00B2B2; wdata[2] = 32'h2222_B2B2;
        req[1] = 1'b1; req[2] = 1'b1;
        wait_ack(1, 10);
        check("dual_ack2_not_yet", 64'(ack[2]), 64'd0);
        wait_ack(2, 10);
        check("dual_ack1_held", 64'(ack[1]), 64'd1);
        check("dual_rdata1_kept", 64'(rdata[1]), 64'd0);
        check("dual_rdata2_kept", 64'(rdata[2]), 64'h0000BEEF);
        req[1] = 1'b0; req[2] = 1'b0;
        @(posedge clk); #1;
        check("dual_acks_clear", 64'(ack[2:1]), 64'd0);
        check("dual_ready", 64'(ready), 64'hF);

        // Priority: port 0 wins whenever it is a candidate
        do_reset();
        push(0, 1'b0, addr_of(0, 0), 32'h0, rd_of(addr_of(0, 0)));
        push(1, 1'b0, addr_of(1, 0), 32'h0, rd_of(addr_of(1, 0)));
        push(0, 1'b0, addr_of(0, 1), 32'h0, rd_of(addr_of(0, 1)));
        push(3, 1'b0, addr_of(3, 0), 32'h0, rd_of(addr_of(3, 0)));
        push(0, 1'b0, addr_of(0, 2), 32'h0, rd_of(addr_of(0, 2)));
        push(1, 1'b0, addr_of(1, 1), 32'h0, rd_of(addr_of(1, 1)));
        run_traffic(3, 2, 0, 1, 1'b0, 200);

        // Round-robin among ports 1..3 (writes leave rdata at its reset value)
        do_reset();
        for (int unsigned k = 0; k < 2; k++)
            for (int unsigned p = 1; p < 4; p++)
                push(p, 1'b1, addr_of(p, k), {8'hC3, addr_of(p, k)}, 32'hFFFF_FFFF);
        run_traffic(0, 2, 2, 2, 1'b1, 200);

        // Abandoned request on port 3
        push(3, 1'b0, 24'h0C0FFE, 32'h0, rd_of(24'h0C0FFE));
        we[3] = 1'b0; addr[3] = 24'h0C0FFE; req[3] = 1'b1;
        @(posedge clk); #1;
        check("aband_mem_req", 64'(mem_req), 64'd1);
        check("aband_grant", 64'(grant_id), 64'd3);
        @(posedge clk); #1;
        req[3] = 1'b0;
        wait_ack(3, 10);
        check("aband_rdata3", 64'(rdata[3]), 64'(rd_of(24'h0C0FFE)));
        @(posedge clk); #1;
        check("aband_ack3_pulse", 64'(ack[3]), 64'd0);
        check("aband_ready3", 64'(ready[3]), 64'd1);

        // Reset while an access is in ISSUE, then a stray mem_ack
        ctl_hold = 1'b1;
        push(1, 1'b0, 24'h0D0D0D, 32'h0, 32'h0);
        we[1] = 1'b0; addr[1] = 24'h0D0D0D; req[1] = 1'b1;
        @(posedge clk); #1;
        check("rstiss_mem_req", 64'(mem_req), 64'd1);
        req[1] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstiss_mem_req_low", 64'(mem_req), 64'd0);
        check("rstiss_ready", 64'(ready), 64'hF);
        check("rstiss_busy", 64'(busy), 64'd0);
        inject_ack = 1'b1;
        @(posedge clk); #1;
        inject_ack = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rstiss_no_ack", 64'(ack), 64'h0);
            check("rstiss_rdata1", 64'(rdata[1]), 64'd0);
            check("rstiss_idle", 64'(mem_req), 64'd0);
        end
        ctl_hold = 1'b0;

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Four-port arbiter that shares the single external SRAM controller between display scanout, the rasterizer's framebuffer and Z-buffer ports, and the CPU. It sits between the requesters and the SRAM controller. It serializes one 32-bit access at a time: display scanout has strict priority, and the other three ports are served round-robin. Each port's ack is held until its requester drops req, so the rasterizer can wait for both framebuffer and Z acks in the same cycle.

## Interface
- Parameters: ADDR_W, 24, word address width; DATA_W, 32, data width.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- For each port p in {0 display, 1 framebuffer, 2 Z-buffer, 3 CPU}:
  - reqp  in  1  request, held until ackp is seen.
  - wep  in  1  1 means write, 0 means read.
  - addrp  in  ADDR_W  word address.
  - wdatap  in  DATA_W  write data.
  - rdatap  out  DATA_W  read data, valid while ackp is high after a read.
  - ackp  out  1  completion, level-held.
  - readyp  out  1  port is idle and can accept a new request.
- mem_req  out  1  access strobe to the SRAM controller.
- mem_we  out  1  write select.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  single-cycle completion pulse from the SRAM controller.
- grant_id  out  2  port currently owning the memory (debug).
- busy  out  1  high when the FSM is not in IDLE.

## Operation
- Per-port status is one of FREE, PEND or DONE.
  - readyp = (status == FREE).
  - ackp = (status == DONE).
- Arbiter FSM has two states, IDLE and ISSUE.
- IDLE, candidate set: ports with reqp=1 and status FREE.
- IDLE, selection:
  - Port 0 wins if it is a candidate.
  - Otherwise the winner is the first candidate among 1, 2, 3 searching circularly after rr_last.
  - If there is no candidate, stay in IDLE.
- IDLE, on a winner:
  - Latch wep, addrp, wdatap into mem_we, mem_addr, mem_wdata.
  - mem_req <= 1, grant_id <= winner, status <= PEND.
  - Go to ISSUE.
  - rr_last updates only when a port in 1..3 wins.
- ISSUE:
  - Hold all mem_* outputs stable until mem_ack.
  - On mem_ack: mem_req <= 0; for a read, rdata[grant] <= mem_rdata; status[grant] <= DONE; go to IDLE.
  - For a write, rdatap keeps its previous value.
- DONE to FREE: when reqp=0 is sampled, status <= FREE on the next edge, so ackp falls one cycle after req falls.
  - A port in DONE is never re-arbitrated, even if req stays high.
- reqp dropped while PEND: the access still completes and the status goes PEND to DONE.
  - That DONE is then cleared on the following edge because req is low.
  - The access is never aborted.
- Inputs of non-granted ports are don't-care; only the granted port's fields are latched, and only at grant.
- rdatap of the other ports is unchanged by a completion.
- mem_ack received while in IDLE is ignored.

## Timing
- Reset (rst=1 at a clk edge), all outputs:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ack0..3=0, rdata0..3=0, ready0..3=1.
  - grant_id=0, busy=0.
- Reset, internal state: FSM IDLE, all status FREE, rr_last=3 so port 1 is served first among 1..3.
- Reset mid-access drops mem_req on the next edge. The pending access is forgotten and produces no ack.
- Latency:
  - req sampled high in IDLE at edge N: mem_req is high after edge N.
  - mem_ack sampled at edge M: ackp is high and mem_req is low after M.
  - Next grant can occur at edge M+1, giving a minimum period of 2 cycles per access plus the controller latency.
- Back-to-back mem_ack in consecutive ISSUE cycles cannot occur, because mem_req is low in between.
- Simultaneous events at one edge: the DONE to FREE clear and a new grant to a different port happen in the same cycle without interaction.
- A port cleared to FREE at edge K becomes a candidate at edge K+1 at the earliest.
- Starvation: port 0 can starve ports 1..3 only if it requests continuously. Among ports 1..3, wait is bounded by 3 grants.

## Test plan
- Single read:
  - Stimulus: req2=1, we2=0, addr2=0x000123; controller returns mem_ack two cycles after mem_req with mem_rdata=0x0000BEEF.
  - Required: mem_addr=0x000123, mem_we=0; then ack2=1 and rdata2=0x0000BEEF; ack2 stays 1 until req2=0 and falls one cycle after it.
- Dual-ack hold:
  - Stimulus: req1 and req2 (both writes) asserted in the same cycle, both held.
  - Required: port 1 granted first, then port 2; ack1 stays high until ack2 rises; both acks are high together in one cycle; each address appears on mem_addr exactly once.
- Priority:
  - Stimulus: req0, req1, req3 asserted together from reset, each dropped on ack and re-asserted after 2 cycles.
  - Required: grant order 0,1,0,3,0,1,... ; port 0 wins every arbitration in which it is a candidate.
- Round-robin:
  - Stimulus: req1..3 held high continuously, re-asserted after each ack clear.
  - Required: grant_id sequence 1,2,3,1,2,3.
- Abandoned request:
  - Stimulus: req3 dropped one cycle after grant.
  - Required: mem_ack still completes the access; ack3 pulses for exactly 1 cycle; ready3 returns to 1.
- Reset in ISSUE:
  - Stimulus: assert rst while mem_req=1.
  - Required: next cycle mem_req=0 and all ready=1; a subsequent mem_ack produces no ack.
